// File: rtl/psum_drain_if.sv
// Output-buffer write channel of the partial-sum drain: valid/ready handshake
// carrying one deskewed row and its write address.
interface psum_drain_if #(
  parameter int COL    = 32,
  parameter int DW     = 16,
  parameter int ADDR_W = 10
) ();
  logic                  out_valid;
  logic                  out_ready;
  logic [COL*DW-1:0]     out_data;
  logic [ADDR_W-1:0]     out_addr;

  modport master (output out_valid, output out_data, output out_addr, input out_ready);
  modport slave  (input out_valid, input out_data, input out_addr, output out_ready);
endinterface

// File: rtl/psum_drain_ctrl.sv
// Deskews the skewed partial-sum stream leaving the systolic array and hands
// aligned rows to the output buffer through a small overflow-flagging FIFO.
module psum_drain_ctrl #(
  parameter int COL        = 32,
  parameter int DW         = 16,
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  conv_finish,
  input  logic [ADDR_W-1:0]     rows_total,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [COL*DW-1:0]     ps_in,
  psum_drain_if.master          out,
  output logic                  busy,
  output logic                  drain_done,
  output logic                  overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CNT_W = $clog2(COL + 1);
  localparam logic [CNT_W-1:0] ALIGN_LAST = (COL > 1) ? CNT_W'(COL - 2) : '0;

  typedef enum logic [2:0] {IDLE, ALIGN, STREAM, FLUSH, DONE} state_t;

  state_t               state_q, state_d;
  logic                 fin_q;
  logic                 start;
  logic [ADDR_W-1:0]    rows_q;
  logic [ADDR_W-1:0]    row_cnt_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic                 full, empty, push, pop, drop;
  logic [COL*DW-1:0]    aligned_p0;
  logic [COL*DW-1:0]    mem [FIFO_DEPTH];

  // Stage p0: column c is delayed COL-1-c cycles so a skewed row lines up.
  for (genvar c = 0; c < COL; c++) begin : g_col
    localparam int D = COL - 1 - c;
    if (D == 0) begin : g_pass
      assign aligned_p0[c*DW +: DW] = ps_in[c*DW +: DW];
    end else begin : g_dly
      logic [DW-1:0] sr [D];
      always_ff @(posedge clk) begin
        sr[0] <= ps_in[c*DW +: DW];
        for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
      end
      assign aligned_p0[c*DW +: DW] = sr[D-1];
    end
  end

  assign start = conv_finish & ~fin_q & (state_q == IDLE);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                 (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);
  assign pop   = !empty && out.out_ready;
  // A full FIFO still accepts a row when the head leaves in the same cycle.
  assign push  = (state_q == STREAM) && (!full || pop);
  assign drop  = (state_q == STREAM) && full && !pop;

  assign out.out_valid = !empty;
  assign out.out_data  = empty ? '0 : mem[rd_ptr_q[PTR_W-2:0]];
  assign out.out_addr  = addr_q;
  assign busy          = (state_q != IDLE);
  assign drain_done    = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (rows_total == '0) ? DONE : ((COL == 1) ? STREAM : ALIGN);
      ALIGN:   if (cnt_q == ALIGN_LAST) state_d = STREAM;
      STREAM:  if (row_cnt_q == rows_q - ADDR_W'(1)) state_d = FLUSH;
      FLUSH:   if (empty) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      fin_q     <= 1'b0;
      rows_q    <= '0;
      row_cnt_q <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      overflow  <= 1'b0;
    end else begin
      state_q <= state_d;
      fin_q   <= conv_finish;
      if (start) begin
        rows_q    <= rows_total;
        addr_q    <= base_addr;
        cnt_q     <= '0;
        row_cnt_q <= '0;
        overflow  <= 1'b0;
      end else begin
        if (state_q == ALIGN)  cnt_q     <= cnt_q + CNT_W'(1);
        // Dropped rows still count so the drain always terminates.
        if (state_q == STREAM) row_cnt_q <= row_cnt_q + ADDR_W'(1);
        if (pop)               addr_q    <= addr_q + ADDR_W'(1);
        if (drop)              overflow  <= 1'b1;
      end
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[PTR_W-2:0]] <= aligned_p0;
  end

endmodule
